// File: rtl/rst_sequencer.sv
// rst_sequencer: turns a raw asynchronous board reset into a set of
// synchronous, sequentially released reset outputs. Assertion is immediate
// (async set), release is synchronised to clk and staggered by HOLD_CYCLES.
// A software request accepted in DONE replays the release sequence.
module rst_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_OUTS    = 3,
   parameter int HOLD_CYCLES = 4,
   parameter int SW_MIN      = 8
) (
   input  logic                clk,
   input  logic                async_rst,
   input  logic                sw_rst_req,
   output logic [NUM_OUTS-1:0] rst_out,
   output logic                rst_done,
   output logic                busy,
   output logic [1:0]          rst_cause
);

   localparam int MAX_CNT = (HOLD_CYCLES > SW_MIN) ? HOLD_CYCLES : SW_MIN;
   localparam int CW      = $clog2(MAX_CNT) + 1;
   localparam int IW      = $clog2(NUM_OUTS) + 1;

   localparam logic [1:0] CAUSE_ASYNC = 2'b01;
   localparam logic [1:0] CAUSE_SW    = 2'b10;

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("rst_sequencer: SYNC_STAGES must be in 2..4");
   end
   if (NUM_OUTS < 1 || NUM_OUTS > 8) begin : g_bad_outs
      $error("rst_sequencer: NUM_OUTS must be in 1..8");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("rst_sequencer: HOLD_CYCLES must be at least 1");
   end
   if (SW_MIN < 1) begin : g_bad_swmin
      $error("rst_sequencer: SW_MIN must be at least 1");
   end

   typedef enum logic [1:0] {
      S_RESET,
      S_SW_HOLD,
      S_RELEASE,
      S_DONE
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_rst_sync;
   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CW-1:0]          r_cnt;
   logic [CW-1:0]          w_cnt_nxt;
   logic [IW-1:0]          r_idx;
   logic [IW-1:0]          w_idx_nxt;
   logic [NUM_OUTS-1:0]    r_rst_out;
   logic [NUM_OUTS-1:0]    w_rst_out_nxt;
   logic [NUM_OUTS-1:0]    w_idx_mask;
   logic                   r_rst_done;
   logic                   r_busy;
   logic [1:0]             r_cause;
   logic [1:0]             w_cause_nxt;

   assign w_rst_sync = r_sync[SYNC_STAGES-1];

   // Deassertion synchroniser: async set to all ones, shifts zeros in once reset drops.
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
      end
   end

   // One-hot mask selecting the output bit due for release.
   always_comb begin
      w_idx_mask = '0;
      for (int i = 0; i < NUM_OUTS; i++) begin
         if (r_idx == IW'(i)) begin
            w_idx_mask[i] = 1'b1;
         end
      end
   end

   // Next-state logic. RESET leaves on the same edge the synchroniser output
   // falls (the stage feeding it is already low), so bit 0 releases exactly
   // HOLD_CYCLES edges after rst_sync goes low.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_idx_nxt     = r_idx;
      w_rst_out_nxt = r_rst_out;
      w_cause_nxt   = r_cause;
      case (r_state)
         S_RESET: begin
            if (!r_sync[SYNC_STAGES-2]) begin
               w_state_nxt = S_RELEASE;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
            end
         end
         S_SW_HOLD: begin
            if (r_cnt == CW'(SW_MIN - 1)) begin
               w_state_nxt = S_RELEASE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_RELEASE: begin
            if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
               w_cnt_nxt     = '0;
               w_rst_out_nxt = r_rst_out & ~w_idx_mask;
               if (r_idx == IW'(NUM_OUTS - 1)) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_idx_nxt = r_idx + IW'(1);
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_DONE: begin
            if (sw_rst_req) begin
               w_state_nxt   = S_SW_HOLD;
               w_cnt_nxt     = '0;
               w_idx_nxt     = '0;
               w_rst_out_nxt = '1;
               w_cause_nxt   = CAUSE_SW;
            end
         end
         default: begin
            w_state_nxt   = S_RESET;
            w_cnt_nxt     = '0;
            w_idx_nxt     = '0;
            w_rst_out_nxt = '1;
         end
      endcase
      // A synchroniser still reporting reset outside RESET means corrupted
      // state; fall back to a full reset rather than releasing anything.
      if (w_rst_sync && r_state != S_RESET) begin
         w_state_nxt   = S_RESET;
         w_cnt_nxt     = '0;
         w_idx_nxt     = '0;
         w_rst_out_nxt = '1;
      end
   end

   // State and registered outputs; async_rst forces the full reset condition.
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         r_state    <= S_RESET;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_rst_out  <= '1;
         r_rst_done <= 1'b0;
         r_busy     <= 1'b1;
         r_cause    <= CAUSE_ASYNC;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_rst_out  <= w_rst_out_nxt;
         r_rst_done <= (w_state_nxt == S_DONE);
         r_busy     <= (w_state_nxt != S_DONE);
         r_cause    <= w_cause_nxt;
      end
   end

   assign rst_out   = r_rst_out;
   assign rst_done  = r_rst_done;
   assign busy      = r_busy;
   assign rst_cause = r_cause;

endmodule

// File: tb/tb_rst_sequencer.sv
// Testbench for rst_sequencer: directed scenarios plus randomized traffic,
// checked against an arithmetic model of the release schedule.
`timescale 1ns/1ps
module tb_rst_sequencer;

   localparam int SYNC = 2;
   localparam int N    = 3;
   localparam int HOLD = 4;
   localparam int SWM  = 8;

   logic         clk;
   logic         async_rst;
   logic         sw_rst_req;
   logic [N-1:0] rst_out;
   logic         rst_done;
   logic         busy;
   logic [1:0]   rst_cause;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Model: every output bit i is released at m_base + m_delay + (i+1)*HOLD.
   // For an async reset m_base is the last edge before release (edge 1 is
   // m_base+1) and m_delay = SYNC; for software m_base is the accept edge.
   int         m_base  = 0;
   int         m_delay = SYNC;
   bit         m_hold  = 1'b1;
   logic [1:0] m_cause = 2'b01;

   rst_sequencer #(
      .SYNC_STAGES(SYNC),
      .NUM_OUTS   (N),
      .HOLD_CYCLES(HOLD),
      .SW_MIN     (SWM)
   ) dut (
      .clk       (clk),
      .async_rst (async_rst),
      .sw_rst_req(sw_rst_req),
      .rst_out   (rst_out),
      .rst_done  (rst_done),
      .busy      (busy),
      .rst_cause (rst_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [N-1:0] exp_out(input int e);
      logic [N-1:0] o;
      for (int i = 0; i < N; i++) begin
         o[i] = m_hold ? 1'b1 : (e < m_base + m_delay + (i + 1) * HOLD);
      end
      return o;
   endfunction

   function automatic logic [6:0] exp_vec();
      logic [N-1:0] o;
      logic         d;
      o = exp_out(cyc);
      d = (o == '0);
      return {o, d, ~d, m_cause};
   endfunction

   // Advance one edge; a pending software request is taken only if the model
   // was complete after the previous edge and async_rst is low.
   task automatic cycle();
      @(posedge clk);
      cyc++;
      if (sw_rst_req && !async_rst && exp_out(cyc - 1) == '0) begin
         m_base  = cyc;
         m_delay = SWM;
         m_cause = 2'b10;
      end
      #1 sw_rst_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic release_async(input int off);
      @(posedge clk);
      cyc++;
      #(off) async_rst = 1'b0;
      m_hold  = 1'b0;
      m_base  = cyc;
      m_delay = SYNC;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({rst_out, rst_done, busy, rst_cause} !== 7'b111_0_1_01)
         $display("FAIL reset_state got=%b want=%b", {rst_out, rst_done, busy, rst_cause}, 7'b111_0_1_01);
      if ({rst_out, rst_done, busy, rst_cause} !== 7'b111_0_1_01) failures++;
      repeat (3) begin
         cycle();
         checks++;
         if ({rst_out, rst_done, busy, rst_cause} !== exp_vec()) begin
            failures++;
            $display("FAIL reset_held edge=%0d got=%b want=%b", cyc, {rst_out, rst_done, busy, rst_cause}, exp_vec());
         end
      end
      release_async(3);
      repeat (16) begin
         cycle();
         checks++;
         if ({rst_out, rst_done, busy, rst_cause} !== exp_vec()) begin
            failures++;
            $display("FAIL poweron rel_edge=%0d got=%b want=%b", cyc - m_base, {rst_out, rst_done, busy, rst_cause}, exp_vec());
         end
         if (cyc - m_base == 6) begin
            checks++;
            if (rst_out !== 3'b110) begin
               failures++;
               $display("FAIL poweron_edge6 got=%b want=110", rst_out);
            end
         end
         if (cyc - m_base == 14) begin
            checks++;
            if ({rst_out, rst_done, busy, rst_cause} !== 7'b000_1_0_01) begin
               failures++;
               $display("FAIL poweron_edge14 got=%b want=0001001", {rst_out, rst_done, busy, rst_cause});
            end
         end
      end
   endtask

   task automatic test_sw(input bit busy_req);
      int e;
      sw_rst_req = 1'b1;
      cycle();
      e = cyc;
      checks++;
      if ({rst_out, rst_done, busy, rst_cause} !== 7'b111_0_1_10) begin
         failures++;
         $display("FAIL sw_accept got=%b want=1110110", {rst_out, rst_done, busy, rst_cause});
      end
      repeat (20) begin
         if (busy_req && cyc == e + 4) sw_rst_req = 1'b1;
         cycle();
         checks++;
         if ({rst_out, rst_done, busy, rst_cause} !== exp_vec()) begin
            failures++;
            $display("FAIL sw_seq busy_req=%0d rel_edge=%0d got=%b want=%b", busy_req, cyc - e, {rst_out, rst_done, busy, rst_cause}, exp_vec());
         end
         if (cyc == e + 12) begin
            checks++;
            if (rst_out !== 3'b110) begin
               failures++;
               $display("FAIL sw_edge12 got=%b want=110", rst_out);
            end
         end
         if (cyc == e + 20) begin
            checks++;
            if ({rst_out, rst_done, busy, rst_cause} !== 7'b000_1_0_10) begin
               failures++;
               $display("FAIL sw_edge20 busy_req=%0d got=%b want=0001010", busy_req, {rst_out, rst_done, busy, rst_cause});
            end
         end
      end
   endtask

   task automatic test_async_mid();
      async_rst = 1'b1;
      m_hold    = 1'b1;
      m_cause   = 2'b01;
      release_async(3);
      repeat (7) begin
         cycle();
         checks++;
         if ({rst_out, rst_done, busy, rst_cause} !== exp_vec()) begin
            failures++;
            $display("FAIL mid_pre rel_edge=%0d got=%b want=%b", cyc - m_base, {rst_out, rst_done, busy, rst_cause}, exp_vec());
         end
      end
      @(posedge clk);
      cyc++;
      #2 async_rst = 1'b1;
      m_hold  = 1'b1;
      m_cause = 2'b01;
      #1;
      checks++;
      if ({rst_out, rst_done, busy, rst_cause} !== 7'b111_0_1_01) begin
         failures++;
         $display("FAIL mid_assert got=%b want=1110101", {rst_out, rst_done, busy, rst_cause});
      end
      @(negedge clk);
      release_async(3);
      repeat (16) begin
         cycle();
         checks++;
         if ({rst_out, rst_done, busy, rst_cause} !== exp_vec()) begin
            failures++;
            $display("FAIL mid_restart rel_edge=%0d got=%b want=%b", cyc - m_base, {rst_out, rst_done, busy, rst_cause}, exp_vec());
         end
      end
   endtask

   task automatic test_glitch();
      #2 async_rst = 1'b1;
      m_hold  = 1'b1;
      m_cause = 2'b01;
      #0.5;
      checks++;
      if ({rst_out, rst_done, busy, rst_cause} !== 7'b111_0_1_01) begin
         failures++;
         $display("FAIL glitch_assert got=%b want=1110101", {rst_out, rst_done, busy, rst_cause});
      end
      #0.5 async_rst = 1'b0;
      m_hold  = 1'b0;
      m_base  = cyc;
      m_delay = SYNC;
      repeat (16) begin
         cycle();
         checks++;
         if ({rst_out, rst_done, busy, rst_cause} !== exp_vec()) begin
            failures++;
            $display("FAIL glitch_seq rel_edge=%0d got=%b want=%b", cyc - m_base, {rst_out, rst_done, busy, rst_cause}, exp_vec());
         end
      end
   endtask

   task automatic test_simultaneous();
      sw_rst_req = 1'b1;
      async_rst  = 1'b1;
      m_hold     = 1'b1;
      m_cause    = 2'b01;
      repeat (3) begin
         cycle();
         checks++;
         if ({rst_out, rst_done, busy, rst_cause} !== exp_vec()) begin
            failures++;
            $display("FAIL simul_held got=%b want=%b", {rst_out, rst_done, busy, rst_cause}, exp_vec());
         end
      end
      release_async(3);
      repeat (16) begin
         cycle();
         checks++;
         if ({rst_out, rst_done, busy, rst_cause} !== exp_vec()) begin
            failures++;
            $display("FAIL simul_seq rel_edge=%0d got=%b want=%b", cyc - m_base, {rst_out, rst_done, busy, rst_cause}, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      int r;
      for (int it = 0; it < 800; it++) begin
         r = $urandom_range(0, 99);
         if (r < 10) begin
            sw_rst_req = 1'b1;
         end else if (r < 12) begin
            #1 async_rst = 1'b1;
            m_hold  = 1'b1;
            m_cause = 2'b01;
            #0.5;
            checks++;
            if (rst_out !== '1 || rst_done !== 1'b0) begin
               failures++;
               $display("FAIL rand_glitch got out=%b done=%b want out=111 done=0", rst_out, rst_done);
            end
            #($urandom_range(1, 2)) async_rst = 1'b0;
            m_hold  = 1'b0;
            m_base  = cyc;
            m_delay = SYNC;
         end else if (r == 12) begin
            async_rst = 1'b1;
            m_hold    = 1'b1;
            m_cause   = 2'b01;
            repeat ($urandom_range(0, 3)) begin
               cycle();
               checks++;
               if ({rst_out, rst_done, busy, rst_cause} !== exp_vec()) begin
                  failures++;
                  $display("FAIL rand_held got=%b want=%b", {rst_out, rst_done, busy, rst_cause}, exp_vec());
               end
            end
            release_async($urandom_range(1, 4));
         end
         cycle();
         checks++;
         if ({rst_out, rst_done, busy, rst_cause} !== exp_vec()) begin
            failures++;
            $display("FAIL rand_step it=%0d got=%b want=%b", it, {rst_out, rst_done, busy, rst_cause}, exp_vec());
         end
      end
   endtask

   initial begin
      async_rst  = 1'b1;
      sw_rst_req = 1'b0;
      test_reset();
      test_sw(1'b0);
      test_sw(1'b1);
      test_async_mid();
      test_glitch();
      test_simultaneous();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
